// File: rtl/stage_memory_pkg.sv
// Shared core definitions for the memory stage: result-select encodings, fault codes,
// FSM states and the MEM/WB payload layout.
package stage_memory_pkg;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef enum logic {ST_IDLE, ST_WAIT} mem_state_t;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus_4;
    logic [31:0] imm_ext;
    logic [4:0]  rd;
  } wb_t;

  // Faults are sticky and the first one recorded is kept.
  function automatic logic [1:0] first_fault(input logic [1:0] cur, input logic [1:0] code);
    return (cur == FAULT_NONE) ? code : cur;
  endfunction

endpackage

// File: rtl/stage_memory.sv
// Pipeline MEM stage: data-memory access plus MEM/WB register; 1 cycle when ack is same-cycle.
// Holds mem_stall while a request waits for ack, aborting with a timeout fault after TIMEOUT stalls.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_clear,
  input  logic        mem_reg_write,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_result_src,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_pc_plus_4,
  input  logic [31:0] mem_imm_ext,
  input  logic [4:0]  mem_rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [1:0]  mem_fault,
  output logic        wb_reg_write,
  output logic [1:0]  wb_result_src,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_pc_plus_4,
  output logic [31:0] wb_imm_ext,
  output logic [4:0]  wb_rd
);

  // The IDLE request cycle is the first stall, so WAIT aborts on its TIMEOUT-th cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  mem_state_t  state, state_n;
  logic [7:0]  wait_cnt, cnt_n;
  logic [1:0]  fault_n;
  wb_t         wb_q, wb_n, in_ctl, lat_ctl;
  logic        lat_we;
  logic [31:0] lat_wdata;
  logic        access, misaligned, latch_en, done;

  assign access     = mem_mem_write | (mem_result_src == RES_LOAD);
  assign misaligned = (mem_alu_result[1:0] != 2'b00);

  assign in_ctl = '{reg_write:  mem_reg_write,
                    result_src: mem_result_src,
                    alu_result: mem_alu_result,
                    read_data:  32'd0,
                    pc_plus_4:  mem_pc_plus_4,
                    imm_ext:    mem_imm_ext,
                    rd:         mem_rd};

  always_comb begin
    state_n    = state;
    cnt_n      = wait_cnt;
    fault_n    = mem_fault;
    wb_n       = '0;
    latch_en   = 1'b0;
    done       = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = mem_alu_result;
    dmem_wdata = mem_write_data;
    mem_stall  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!access) begin
          wb_n = in_ctl;
        end else if (misaligned) begin
          fault_n = first_fault(mem_fault, FAULT_MISALIGN);
        end else begin
          dmem_req = 1'b1;
          dmem_we  = mem_mem_write;
          if (dmem_ack) begin
            wb_n           = in_ctl;
            wb_n.read_data = dmem_rdata;
            done           = 1'b1;
          end else begin
            mem_stall = 1'b1;
            latch_en  = 1'b1;
            cnt_n     = '0;
            state_n   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Upstream may change while frozen; only the captured request is presented.
        dmem_req   = 1'b1;
        dmem_we    = lat_we;
        dmem_addr  = lat_ctl.alu_result;
        dmem_wdata = lat_wdata;
        if (dmem_ack) begin
          wb_n           = lat_ctl;
          wb_n.read_data = dmem_rdata;
          done           = 1'b1;
          state_n        = ST_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          fault_n = first_fault(mem_fault, FAULT_TIMEOUT);
          state_n = ST_IDLE;
        end else begin
          mem_stall = 1'b1;
          cnt_n     = wait_cnt + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A completing transaction must not be lost to a hazard-unit bubble.
    if (wb_clear && !done) wb_n = '0;
    if (!reset) begin
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      mem_fault <= FAULT_NONE;
      wb_q      <= '0;
      lat_ctl   <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else begin
      state     <= state_n;
      wait_cnt  <= cnt_n;
      mem_fault <= fault_n;
      wb_q      <= wb_n;
      if (latch_en) begin
        lat_ctl   <= in_ctl;
        lat_we    <= mem_mem_write;
        lat_wdata <= mem_write_data;
      end
    end
  end

  assign wb_reg_write  = wb_q.reg_write;
  assign wb_result_src = wb_q.result_src;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_read_data  = wb_q.read_data;
  assign wb_pc_plus_4  = wb_q.pc_plus_4;
  assign wb_imm_ext    = wb_q.imm_ext;
  assign wb_rd         = wb_q.rd;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: single-cycle vector table plus hand-written stall,
// timeout, fault and reset sequences (TIMEOUT=4).
module tb_stage_memory;

  logic        clk = 1'b0;
  logic        reset, wb_clear;
  logic        mem_reg_write, mem_mem_write;
  logic [1:0]  mem_result_src;
  logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
  logic [4:0]  mem_rd;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall;
  logic [1:0]  mem_fault;
  logic        wb_reg_write;
  logic [1:0]  wb_result_src;
  logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext;
  logic [4:0]  wb_rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stage_memory #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .wb_clear(wb_clear),
    .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
    .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
    .mem_write_data(mem_write_data), .mem_pc_plus_4(mem_pc_plus_4),
    .mem_imm_ext(mem_imm_ext), .mem_rd(mem_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_fault(mem_fault),
    .wb_reg_write(wb_reg_write), .wb_result_src(wb_result_src),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .wb_pc_plus_4(wb_pc_plus_4), .wb_imm_ext(wb_imm_ext), .wb_rd(wb_rd)
  );

  typedef struct {
    logic        clr, rw, mw;
    logic [1:0]  src;
    logic [31:0] alu, wdata, pc4, imm;
    logic [4:0]  rd;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req, e_we, e_stall, e_rw;
    logic [1:0]  e_src;
    logic [31:0] e_rdat, e_alu, e_pc4, e_imm;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic clr, input logic rw, input logic mw, input logic [1:0] src,
                        input logic [31:0] alu, input logic [31:0] wdata, input logic [31:0] pc4,
                        input logic [31:0] imm, input logic [4:0] rd, input logic ack,
                        input logic [31:0] rdata);
    wb_clear = clr; mem_reg_write = rw; mem_mem_write = mw; mem_result_src = src;
    mem_alu_result = alu; mem_write_data = wdata; mem_pc_plus_4 = pc4;
    mem_imm_ext = imm; mem_rd = rd; dmem_ack = ack; dmem_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n_st;
    bit  ended;

    vecs[0] = '{0,1,0,2'b00,32'h0000_1235,32'h0,32'h0000_0104,32'h10,5'd3,0,32'hFFFF_FFFF,
                0,0,0,1,2'b00,32'h0,32'h0000_1235,32'h0000_0104,32'h10,5'd3};
    vecs[1] = '{0,1,0,2'b01,32'h0000_0100,32'h0,32'h0000_0108,32'h100,5'd5,1,32'hDEAD_BEEF,
                1,0,0,1,2'b01,32'hDEAD_BEEF,32'h0000_0100,32'h0000_0108,32'h100,5'd5};
    vecs[2] = '{0,0,1,2'b00,32'h0000_0040,32'h1234_5678,32'h0000_010C,32'h40,5'd0,1,32'h0,
                1,1,0,0,2'b00,32'h0,32'h0000_0040,32'h0000_010C,32'h40,5'd0};
    vecs[3] = '{0,1,0,2'b10,32'hFFFF_FFFE,32'h0,32'h0000_2004,32'h0,5'd31,1,32'h1111_1111,
                0,0,0,1,2'b10,32'h0,32'hFFFF_FFFE,32'h0000_2004,32'h0,5'd31};
    vecs[4] = '{0,1,0,2'b11,32'h0000_0008,32'h0,32'h0000_2008,32'hABCD_0000,5'd12,0,32'h0,
                0,0,0,1,2'b11,32'h0,32'h0000_0008,32'h0000_2008,32'hABCD_0000,5'd12};
    vecs[5] = '{1,1,0,2'b00,32'h0000_0077,32'h0,32'h0000_200C,32'h5,5'd4,0,32'h0,
                0,0,0,0,2'b00,32'h0,32'h0,32'h0,32'h0,5'd0};
    vecs[6] = '{1,1,0,2'b01,32'h0000_0F00,32'h0,32'h0000_2010,32'h0,5'd6,1,32'hA5A5_0001,
                1,0,0,1,2'b01,32'hA5A5_0001,32'h0000_0F00,32'h0000_2010,32'h0,5'd6};

    // Reset state
    reset = 1'b0;
    set_in(0,0,0,2'b00,0,0,0,0,0,0,0);
    tick(); tick();
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_fault", mem_fault, 0);
    chk("rst_wb_rw", wb_reg_write, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    reset = 1'b1;

    // Single-cycle table
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].clr, vecs[i].rw, vecs[i].mw, vecs[i].src, vecs[i].alu, vecs[i].wdata,
             vecs[i].pc4, vecs[i].imm, vecs[i].rd, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
      chk($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
      chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].e_stall);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu);
        chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
      end
      tick();
      chk($sformatf("v%0d_wb_rw", i), wb_reg_write, vecs[i].e_rw);
      chk($sformatf("v%0d_wb_src", i), wb_result_src, vecs[i].e_src);
      chk($sformatf("v%0d_wb_rdat", i), wb_read_data, vecs[i].e_rdat);
      chk($sformatf("v%0d_wb_alu", i), wb_alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d_wb_pc4", i), wb_pc_plus_4, vecs[i].e_pc4);
      chk($sformatf("v%0d_wb_imm", i), wb_imm_ext, vecs[i].e_imm);
      chk($sformatf("v%0d_wb_rd", i), wb_rd, vecs[i].e_rd);
      chk($sformatf("v%0d_fault", i), mem_fault, 0);
    end

    // Store acked after 3 stalled cycles; upstream changes while frozen, wb_clear mid-wait
    set_in(0,0,1,2'b00,32'h40,32'h1234_5678,32'h300,32'h40,5'd7,0,0);
    #1;
    chk("st_c1_stall", mem_stall, 1);
    chk("st_c1_we", dmem_we, 1);
    chk("st_c1_addr", dmem_addr, 32'h40);
    tick();
    chk("st_c1_bubble", wb_reg_write, 0);
    set_in(1,1,0,2'b00,32'hFFFF_FFF0,32'h0,32'h0,32'h0,5'd1,0,0);
    #1;
    chk("st_c2_stall", mem_stall, 1);
    chk("st_c2_req", dmem_req, 1);
    chk("st_c2_we", dmem_we, 1);
    chk("st_c2_addr", dmem_addr, 32'h40);
    chk("st_c2_wdata", dmem_wdata, 32'h1234_5678);
    tick();
    wb_clear = 1'b0;
    #1;
    chk("st_c3_stall", mem_stall, 1);
    chk("st_c3_addr", dmem_addr, 32'h40);
    tick();
    chk("st_c3_bubble", wb_reg_write, 0);
    dmem_ack = 1'b1;
    #1;
    chk("st_c4_stall", mem_stall, 0);
    chk("st_c4_req", dmem_req, 1);
    tick();
    chk("st_done_alu", wb_alu_result, 32'h40);
    chk("st_done_rd", wb_rd, 7);
    chk("st_done_pc4", wb_pc_plus_4, 32'h300);
    chk("st_done_rw", wb_reg_write, 0);
    dmem_ack = 1'b0;
    #1;
    chk("st_idle_req", dmem_req, 0);
    chk("st_idle_stall", mem_stall, 0);
    tick();
    chk("st_next_rw", wb_reg_write, 1);

    // Timeout: TIMEOUT=4, no ack
    set_in(0,1,0,2'b01,32'h300,32'h0,32'h400,32'h0,5'd8,0,0);
    n_st = 0;
    ended = 0;
    for (int i = 0; i < 20 && !ended; i++) begin
      #1;
      if (mem_stall) begin
        n_st++;
        @(posedge clk);
      end else begin
        ended = 1;
      end
    end
    chk("to_ended", ended, 1);
    chk("to_stall_cycles", n_st, 4);
    tick();
    chk("to_bubble", wb_reg_write, 0);
    chk("to_fault", mem_fault, 2'b10);
    set_in(0,1,0,2'b01,32'h102,32'h0,32'h0,32'h0,5'd2,0,0);
    #1;
    chk("to_idle_req", dmem_req, 0);
    tick();
    chk("fault_sticky", mem_fault, 2'b10);

    // Reset, then misaligned load
    reset = 1'b0;
    set_in(0,0,0,2'b00,0,0,0,0,0,0,0);
    tick();
    chk("rst2_fault", mem_fault, 0);
    reset = 1'b1;
    set_in(0,1,0,2'b01,32'h102,32'h0,32'h0,32'h0,5'd2,1,32'h7777_7777);
    #1;
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", mem_stall, 0);
    tick();
    chk("mis_fault", mem_fault, 2'b01);
    chk("mis_bubble", wb_reg_write, 0);
    chk("mis_rd", wb_rd, 0);

    // Late ack coinciding with wb_clear still writes back
    set_in(0,1,0,2'b01,32'h200,32'h0,32'h500,32'h0,5'd9,0,0);
    #1;
    chk("lc_stall", mem_stall, 1);
    tick();
    wb_clear = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    #1;
    chk("lc_ack_stall", mem_stall, 0);
    tick();
    chk("lc_rw", wb_reg_write, 1);
    chk("lc_rdat", wb_read_data, 32'hCAFE_F00D);
    chk("lc_rd", wb_rd, 9);
    chk("lc_alu", wb_alu_result, 32'h200);
    chk("lc_fault_kept", mem_fault, 2'b01);

    // Reset asserted mid-WAIT, then a late ack
    set_in(0,1,0,2'b01,32'h400,32'h0,32'h600,32'h0,5'd10,0,0);
    tick();
    #1;
    chk("rw_wait_stall", mem_stall, 1);
    reset = 1'b0;
    #1;
    chk("rw_rst_req", dmem_req, 0);
    chk("rw_rst_stall", mem_stall, 0);
    tick();
    chk("rw_rst_fault", mem_fault, 0);
    chk("rw_rst_rw", wb_reg_write, 0);
    reset = 1'b1;
    set_in(0,0,0,2'b00,0,0,0,0,0,1,32'h5555_5555);
    #1;
    chk("rw_late_req", dmem_req, 0);
    chk("rw_late_stall", mem_stall, 0);
    tick();
    chk("rw_late_rdat", wb_read_data, 0);
    chk("rw_late_rd", wb_rd, 0);
    set_in(0,1,0,2'b01,32'h800,32'h0,32'h0,32'h0,5'd11,0,0);
    #1;
    chk("rw_idle_stall", mem_stall, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 SHALL have clk, input, 1: rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have wb_clear, input, 1: synchronous bubble request from the hazard unit for the MEM/WB register.
REQ-004 SHALL have mem_reg_write, input, 1: register-file write enable from EX/MEM.
REQ-005 SHALL have mem_mem_write, input, 1: store request.
REQ-006 SHALL have mem_result_src, input, 2: result select (00 alu, 01 load data, 10 pc+4, 11 imm); 01 denotes a load.
REQ-007 SHALL have mem_alu_result, input, 32: effective address or ALU value.
REQ-008 SHALL have mem_write_data, input, 32: store data.
REQ-009 SHALL have mem_pc_plus_4, input, 32, and mem_imm_ext, input, 32: pass-through values.
REQ-010 SHALL have mem_rd, input, 5: destination register.
REQ-011 SHALL have dmem_req, output, 1; dmem_we, output, 1; dmem_addr, output, 32; dmem_wdata, output, 32: data-memory request channel.
REQ-012 SHALL have dmem_ack, input, 1, and dmem_rdata, input, 32: data-memory response, with rdata valid when ack=1.
REQ-013 SHALL have mem_stall, output, 1: freeze request to the hazard unit.
REQ-014 SHALL have mem_fault, output, 2: sticky fault code (00 none, 01 misaligned, 10 timeout).
REQ-015 SHALL have wb_reg_write, output, 1; wb_result_src, output, 2; wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext, each output, 32; wb_rd, output, 5: MEM/WB register.
REQ-016 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before abort.

Function
REQ-017 SHALL define an access as mem_mem_write=1 or mem_result_src=01.
REQ-018 SHALL implement the FSM states IDLE and WAIT.
REQ-019 IDLE with an aligned access: dmem_req=1, dmem_we=mem_mem_write, dmem_addr=mem_alu_result, dmem_wdata=mem_write_data, all combinational.
REQ-020 IDLE with access and dmem_ack=1 in the same cycle: complete with zero stall; the MEM/WB register loads inputs and dmem_rdata at the edge.
REQ-021 IDLE with access and dmem_ack=0: latch we/addr/wdata/control/rd into internal registers, go to WAIT, mem_stall=1 that cycle.
REQ-022 WAIT: drive dmem_req=1 from latched values only; mem_stall=1 while dmem_ack=0; MEM/WB register loads a bubble (wb_reg_write=0) each stalled cycle.
REQ-023 WAIT with dmem_ack=1: mem_stall=0; the MEM/WB register loads latched control plus dmem_rdata; go to IDLE.
REQ-024 The WAIT cycle counter SHALL be 8 bits and reset on WAIT entry; when it reaches TIMEOUT without ack: go to IDLE, mem_stall=0, load a bubble, set mem_fault=10.
REQ-025 An access with addr[1:0]!=0 SHALL issue no request, load a bubble, set mem_fault=01, and SHALL NOT stall.
REQ-026 mem_fault SHALL be sticky, with the first fault winning; it clears only on reset.
REQ-027 Non-access instructions SHALL pass to MEM/WB in 1 cycle, with wb_read_data=0.
REQ-028 wb_clear=1 SHALL zero all wb_* outputs at the edge; it SHALL NOT abort a WAIT transaction; the completing edge of a transaction has priority over wb_clear.
REQ-029 Stores SHALL force wb_reg_write to the input value, as decoded upstream; loads SHALL write wb_read_data=dmem_rdata.

Reset
REQ-030 reset=0 at an edge SHALL set the FSM to IDLE, the counter to 0, mem_fault to 00, all wb_* to 0, and all latches to 0.
REQ-031 While reset=0, dmem_req=0 and mem_stall=0, including reset asserted mid-WAIT; a late ack after reset SHALL be ignored.

Structure
REQ-032 Result-select encodings, fault codes and FSM state enum SHALL live in the shared core package.
REQ-033 The timeout counter SHALL be in the module itself; there SHALL be no sub-module.

Verification
REQ-034 Load addr 0x100 with ack same cycle, rdata 0xDEADBEEF -> next cycle wb_read_data=0xDEADBEEF, wb_reg_write=1, mem_stall never 1.
REQ-035 Store addr 0x40, data 0x12345678, ack after 3 cycles -> mem_stall=1 for 3 cycles, dmem_addr/wdata stable, dmem_we=1, 3 bubbles, then completion.
REQ-036 Load addr 0x102 -> dmem_req=0, mem_fault=01, wb_reg_write=0, no stall.
REQ-037 TIMEOUT=4, no ack -> mem_stall=1 for 4 cycles, then IDLE, mem_fault=10, bubble.
REQ-038 reset=0 during WAIT, then ack -> outputs zero, state IDLE, ack ignored.
REQ-039 wb_clear=1 on the completing ack edge -> load result still written.
